// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, coin codes and coin value mapping
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int COIN_W = 5;

  function automatic logic [COIN_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_20: return 5'd20;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// rtl/vend_coin_decode.sv - combinational coin code to value decoder
module vend_coin_decode
  import vend_pkg::*;
(
  input  logic [1:0]        coin_code,
  output logic [COIN_W-1:0] value,
  output logic              valid
);

  assign value = coin_value(coin_code);
  assign valid = (coin_code != COIN_NONE);

endmodule

// File: rtl/vend_ctrl_change.sv
// rtl/vend_ctrl_change.sv - coin vending controller with unit-by-unit change payout
module vend_ctrl_change
  import vend_pkg::*;
#(
  parameter int BAL_W       = 8,
  parameter int PRICE       = 15,
  parameter int MAX_BAL     = 60,
  parameter int CHANGE_UNIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_code,
  input  logic             cancel,
  input  logic             vend_ack,
  input  logic             change_ack,
  output logic             vend_req,
  output logic             change_req,
  output logic             coin_reject,
  output logic             busy,
  output logic [BAL_W-1:0] balance
);

  state_t             state, state_nxt;
  logic [BAL_W-1:0]   bal_nxt;
  logic               rej_nxt;
  logic               coin_accept;
  logic [COIN_W-1:0]  coin_val;
  logic               coin_ok;
  logic [BAL_W:0]     sum;
  logic               fits;
  logic [BAL_W-1:0]   after_vend;

  vend_coin_decode u_decode (
    .coin_code (coin_code),
    .value     (coin_val),
    .valid     (coin_ok)
  );

  // One extra bit keeps the cap compare free of wrap-around.
  assign sum        = {1'b0, balance} + (BAL_W+1)'(coin_val);
  assign fits       = coin_valid && coin_ok && !cancel && (sum <= (BAL_W+1)'(MAX_BAL));
  assign after_vend = balance - BAL_W'(PRICE);

  always_comb begin
    state_nxt   = state;
    bal_nxt     = balance;
    coin_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fits) begin
          coin_accept = 1'b1;
          state_nxt   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_nxt = (balance != '0) ? ST_CHANGE : ST_IDLE;
        end else begin
          coin_accept = fits;
          if (balance >= BAL_W'(PRICE)) state_nxt = ST_VEND;
        end
      end
      ST_VEND: begin
        if (vend_ack) begin
          bal_nxt   = after_vend;
          state_nxt = (after_vend != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (change_ack) begin
          if (balance <= BAL_W'(CHANGE_UNIT)) begin
            bal_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            bal_nxt = balance - BAL_W'(CHANGE_UNIT);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (coin_accept) bal_nxt = sum[BAL_W-1:0];
    rej_nxt = coin_valid && !coin_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      balance     <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      balance     <= bal_nxt;
      coin_reject <= rej_nxt;
    end
  end

  assign vend_req   = (state == ST_VEND);
  assign change_req = (state == ST_CHANGE);
  assign busy       = vend_req || change_req;

endmodule
